// File: rtl/signal_sequencer.sv
// Two-road signal sequencer: road 1 rests in green, and road 2 gets a fixed-length cycle on demand.
// Pedestrian requests are latched and served as a walk indication on the next green of that road.
module signal_sequencer #(
  parameter int unsigned T_G1MIN = 16,
  parameter int unsigned T_Y     = 4,
  parameter int unsigned T_AR    = 2,
  parameter int unsigned T_G2    = 12
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       FM,
  input  logic       PED1,
  input  logic       PED2,
  input  logic       TEST,
  output logic       GRN1,
  output logic       YLW1,
  output logic       RED1,
  output logic       GRN2,
  output logic       YLW2,
  output logic       RED2,
  output logic       WALK1,
  output logic       WALK2,
  output logic [2:0] PHASE
);

  localparam logic [2:0] StG1  = 3'd0;
  localparam logic [2:0] StY1  = 3'd1;
  localparam logic [2:0] StAr1 = 3'd2;
  localparam logic [2:0] StG2  = 3'd3;
  localparam logic [2:0] StY2  = 3'd4;
  localparam logic [2:0] StAr2 = 3'd5;

  localparam logic [7:0] LdG1 = 8'(T_G1MIN - 1);
  localparam logic [7:0] LdY  = 8'(T_Y - 1);
  localparam logic [7:0] LdAr = 8'(T_AR - 1);
  localparam logic [7:0] LdG2 = 8'(T_G2 - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ped1_pend_q, ped1_pend_d;
  logic       ped2_pend_q, ped2_pend_d;
  logic       walk1_on_q, walk1_on_d;
  logic       walk2_on_q, walk2_on_d;
  logic [7:0] load_val;

  always_comb begin
    state_d = state_q;
    if (timer_q == 8'd0) begin
      case (state_q)
        StG1:    if (FM || ped2_pend_q) state_d = StY1;
        StY1:    state_d = StAr1;
        StAr1:   state_d = StG2;
        StG2:    state_d = StY2;
        StY2:    state_d = StAr2;
        StAr2:   state_d = StG1;
        default: state_d = StAr2;
      endcase
    end
  end

  always_comb begin
    case (state_d)
      StG1:        load_val = LdG1;
      StY1, StY2:  load_val = LdY;
      StG2:        load_val = LdG2;
      default:     load_val = LdAr;
    endcase
  end

  always_comb begin
    timer_d     = (timer_q != 8'd0) ? timer_q - 8'd1 : 8'd0;
    ped1_pend_d = ped1_pend_q | PED1;
    ped2_pend_d = ped2_pend_q | PED2;
    walk1_on_d  = walk1_on_q;
    walk2_on_d  = walk2_on_q;

    if (state_d != state_q) timer_d = TEST ? 8'd0 : load_val;

    // Green entry serves the request pending so far; a same-cycle request waits for the next visit.
    if (state_d == StG1 && state_q != StG1) begin
      walk1_on_d  = ped1_pend_q;
      ped1_pend_d = PED1;
    end else if (state_q == StG1 && state_d != StG1) begin
      walk1_on_d = 1'b0;
    end

    if (state_d == StG2 && state_q != StG2) begin
      walk2_on_d  = ped2_pend_q;
      ped2_pend_d = PED2;
    end else if (state_q == StG2 && state_d != StG2) begin
      walk2_on_d = 1'b0;
    end
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      state_q     <= StAr2;
      timer_q     <= LdAr;
      ped1_pend_q <= 1'b0;
      ped2_pend_q <= 1'b0;
      walk1_on_q  <= 1'b0;
      walk2_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ped1_pend_q <= ped1_pend_d;
      ped2_pend_q <= ped2_pend_d;
      walk1_on_q  <= walk1_on_d;
      walk2_on_q  <= walk2_on_d;
    end
  end

  always_comb begin
    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = 6'b001_001;
    case (state_q)
      StG1:    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = 6'b100_001;
      StY1:    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = 6'b010_001;
      StG2:    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = 6'b001_100;
      StY2:    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = 6'b001_010;
      default: {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = 6'b001_001;
    endcase
  end

  assign WALK1 = (state_q == StG1) && walk1_on_q;
  assign WALK2 = (state_q == StG2) && walk2_on_q;
  assign PHASE = state_q;

endmodule

// File: tb/tb_signal_sequencer.sv
// Directed bench for signal_sequencer: segment tables of {inputs, expected phase/walk} per cycle,
// plus a hand-written mid-phase reset sequence.
module tb_signal_sequencer;

  logic       CK = 1'b0;
  logic       CLR, FM, PED1, PED2, TEST;
  logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2, WALK1, WALK2;
  logic [2:0] PHASE;

  int n_vec = 0;
  int n_err = 0;

  signal_sequencer dut (
    .CK(CK), .CLR(CLR), .FM(FM), .PED1(PED1), .PED2(PED2), .TEST(TEST),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1), .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .WALK1(WALK1), .WALK2(WALK2), .PHASE(PHASE)
  );

  always #5 CK = ~CK;

  // Inputs apply during cycles lo..hi; expected outputs hold during those cycles.
  typedef struct {
    int         lo;
    int         hi;
    logic       fm;
    logic       test;
    logic       ped1;
    logic       ped2;
    logic [2:0] ph;
    logic       w1;
    logic       w2;
  } seg_t;

  seg_t tbl[$];

  function automatic logic [5:0] lamps_of(input logic [2:0] ph);
    case (ph)
      3'd0:    return 6'b100_001;
      3'd1:    return 6'b010_001;
      3'd3:    return 6'b001_100;
      3'd4:    return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction

  task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int c, input logic [2:0] ph,
                             input logic w1, input logic w2);
    chk({tag, ".phase"}, c, 8'(PHASE), 8'(ph));
    chk({tag, ".lamps"}, c, 8'({GRN1, YLW1, RED1, GRN2, YLW2, RED2}), 8'(lamps_of(ph)));
    chk({tag, ".walk"}, c, 8'({WALK1, WALK2}), 8'({w1, w2}));
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle after the reset edge).
  task automatic do_reset();
    @(negedge CK);
    CLR = 1'b1; FM = 1'b0; PED1 = 1'b0; PED2 = 1'b0; TEST = 1'b0;
    @(negedge CK);
    CLR = 1'b0;
  endtask

  task automatic add(input int lo, input int hi, input logic fm, input logic test,
                     input logic p1, input logic p2, input logic [2:0] ph,
                     input logic w1, input logic w2);
    seg_t s;
    s.lo = lo; s.hi = hi; s.fm = fm; s.test = test; s.ped1 = p1; s.ped2 = p2;
    s.ph = ph; s.w1 = w1; s.w2 = w2;
    tbl.push_back(s);
  endtask

  task automatic run_table(input string tag);
    do_reset();
    foreach (tbl[i]) begin
      for (int c = tbl[i].lo; c <= tbl[i].hi; c++) begin
        check_cycle(tag, c, tbl[i].ph, tbl[i].w1, tbl[i].w2);
        FM = tbl[i].fm; TEST = tbl[i].test; PED1 = tbl[i].ped1; PED2 = tbl[i].ped2;
        @(negedge CK);
      end
    end
    PED1 = 1'b0; PED2 = 1'b0; TEST = 1'b0;
    tbl.delete();
  endtask

  initial begin
    CLR = 1'b1; FM = 1'b0; PED1 = 1'b0; PED2 = 1'b0; TEST = 1'b0;

    // No demand: G1 rests indefinitely.
    add(0, 1, 0, 0, 0, 0, 5, 0, 0);
    add(2, 110, 0, 0, 0, 0, 0, 0, 0);
    run_table("idle");

    // Constant road-2 demand: one full cycle.
    add(0, 1, 1, 0, 0, 0, 5, 0, 0);
    add(2, 17, 1, 0, 0, 0, 0, 0, 0);
    add(18, 21, 1, 0, 0, 0, 1, 0, 0);
    add(22, 23, 1, 0, 0, 0, 2, 0, 0);
    add(24, 35, 1, 0, 0, 0, 3, 0, 0);
    add(36, 39, 1, 0, 0, 0, 4, 0, 0);
    add(40, 41, 1, 0, 0, 0, 5, 0, 0);
    add(42, 45, 1, 0, 0, 0, 0, 0, 0);
    run_table("fm");

    // PED2 alone calls the road-2 cycle and is served once.
    add(0, 1, 0, 0, 0, 0, 5, 0, 0);
    add(2, 4, 0, 0, 0, 0, 0, 0, 0);
    add(5, 5, 0, 0, 0, 1, 0, 0, 0);
    add(6, 17, 0, 0, 0, 0, 0, 0, 0);
    add(18, 21, 0, 0, 0, 0, 1, 0, 0);
    add(22, 23, 0, 0, 0, 0, 2, 0, 0);
    add(24, 35, 0, 0, 0, 0, 3, 0, 1);
    add(36, 39, 0, 0, 0, 0, 4, 0, 0);
    add(40, 41, 0, 0, 0, 0, 5, 0, 0);
    add(42, 70, 0, 0, 0, 0, 0, 0, 0);
    run_table("ped2");

    // Requests on the green-entry edge wait for the following visit.
    add(0, 0, 1, 0, 0, 0, 5, 0, 0);
    add(1, 1, 1, 0, 1, 0, 5, 0, 0);
    add(2, 17, 1, 0, 0, 0, 0, 0, 0);
    add(18, 21, 1, 0, 0, 0, 1, 0, 0);
    add(22, 22, 1, 0, 0, 0, 2, 0, 0);
    add(23, 23, 1, 0, 0, 1, 2, 0, 0);
    add(24, 35, 1, 0, 0, 0, 3, 0, 0);
    add(36, 39, 1, 0, 0, 0, 4, 0, 0);
    add(40, 41, 1, 0, 0, 0, 5, 0, 0);
    add(42, 57, 1, 0, 0, 0, 0, 1, 0);
    add(58, 61, 1, 0, 0, 0, 1, 0, 0);
    add(62, 63, 1, 0, 0, 0, 2, 0, 0);
    add(64, 75, 1, 0, 0, 0, 3, 0, 1);
    add(76, 79, 1, 0, 0, 0, 4, 0, 0);
    add(80, 81, 1, 0, 0, 0, 5, 0, 0);
    add(82, 85, 1, 0, 0, 0, 0, 0, 0);
    run_table("edge");

    // Test mode: reset-loaded AR2 still takes 2 cycles, then each phase lasts 1 cycle.
    add(0, 1, 1, 1, 0, 0, 5, 0, 0);
    for (int k = 0; k < 12; k++) add(2 + k, 2 + k, 1, 1, 0, 0, 3'(k % 6), 0, 0);
    run_table("test");

    // TEST raised mid-G1 leaves the loaded timer alone.
    add(0, 1, 1, 0, 0, 0, 5, 0, 0);
    add(2, 4, 1, 0, 0, 0, 0, 0, 0);
    add(5, 17, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) add(18 + k, 18 + k, 1, 1, 0, 0, 3'((k + 1) % 6), 0, 0);
    run_table("midtest");

    // Reset during G2 with ped1 pending: pending lost, AR2 for 2 cycles, then G1 without walk.
    do_reset();
    FM = 1'b1;
    for (int c = 0; c < 26; c++) begin
      PED1 = (c == 5);
      @(negedge CK);
    end
    check_cycle("clr.pre", 26, 3, 0, 0);
    CLR = 1'b1; TEST = 1'b1; PED2 = 1'b1;
    @(negedge CK);
    CLR = 1'b0; TEST = 1'b0; PED2 = 1'b0;
    check_cycle("clr.ar2a", 27, 5, 0, 0);
    @(negedge CK);
    check_cycle("clr.ar2b", 28, 5, 0, 0);
    for (int c = 29; c <= 44; c++) begin
      @(negedge CK);
      check_cycle("clr.g1", c, 0, 0, 0);
    end
    @(negedge CK);
    check_cycle("clr.y1", 45, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
